lcd_sequencer: RTL and testbench

//  Bus-slave controller that owns the HD44780-style character LCD port. After reset it runs
//  the power-up init sequence, then drains a small FIFO of CPU-written command/data bytes to
//  the LCD with correct E-pulse and settle timing. Sits between the CPU bus fabric and the pins.

---
 rtl/lcd_pkg.sv | 47 ++++
 rtl/lcd_bus_if.sv | 12 +
 rtl/lcd_cmd_fifo.sv | 54 +++++
 rtl/lcd_sequencer.sv | 233 +++++++++++++++++++++++
 tb/tb_lcd_sequencer.sv | 340 ++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the character-LCD sequencer: FSM states, register map,
// STATUS bit positions and the power-up init command ROM.
package lcd_pkg;

  typedef enum logic [3:0] {
    S_POWERUP,
    S_INIT_LOAD,
    S_IDLE,
    S_SETUP,
    S_PULSE,
    S_HOLD,
    S_WAIT,
    S_POLL_PULSE,
    S_POLL_LOW
  } lcd_state_t;

  localparam logic [1:0] ADDR_CMD    = 2'd0;
  localparam logic [1:0] ADDR_DATA   = 2'd1;
  localparam logic [1:0] ADDR_STATUS = 2'd2;
  localparam logic [1:0] ADDR_CTRL   = 2'd3;

  localparam int ST_FULL      = 1;
  localparam int ST_EMPTY     = 2;
  localparam int ST_BUSY      = 3;
  localparam int ST_INIT_DONE = 4;
  localparam int ST_OVERFLOW  = 5;

  localparam int INIT_LEN = 8;

  function automatic logic [7:0] init_rom(input logic [2:0] idx);
    logic [7:0] v;
    case (idx)
      3'd0, 3'd1, 3'd2, 3'd3: v = 8'h38;
      3'd4:                   v = 8'h08;
      3'd5:                   v = 8'h01;
      3'd6:                   v = 8'h06;
      default:                v = 8'h0C;
    endcase
    return v;
  endfunction

  // Clear display / return home need the long settle time.
  function automatic logic is_slow_cmd(input logic rs, input logic [7:0] d);
    return !rs && (d >= 8'h01) && (d <= 8'h03);
  endfunction

endpackage

// File: rtl/lcd_bus_if.sv
// CPU-side register bus of the LCD sequencer (strobes, address, data, byte enables).
interface lcd_bus_if;
  logic        read;
  logic        write;
  logic [1:0]  address;
  logic [31:0] writedata;
  logic [3:0]  be;
  logic [31:0] readdata;

  modport master (output read, write, address, writedata, be, input readdata);
  modport slave  (input read, write, address, writedata, be, output readdata);
endinterface

// File: rtl/lcd_cmd_fifo.sv
// Small synchronous FIFO of {rs,data} entries; head is visible combinationally so a
// pop can latch it in the same cycle.
module lcd_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty,
  output logic [$clog2(DEPTH):0] o_count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_dout    = r_mem[r_rd_ptr];
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/lcd_sequencer.sv
// HD44780-style LCD sequencer: power-up init, then drains CPU-written bytes to the pins.
// Optional LCD_BUSYFLAG_EN replaces post-init fixed settle delays with busy-flag polling.
module lcd_sequencer
  import lcd_pkg::*;
#(
  parameter int unsigned INIT_WAIT_CYC  = 1000000,
  parameter int unsigned E_PULSE_CYC    = 24,
  parameter int unsigned CMD_WAIT_CYC   = 2000,
  parameter int unsigned CLEAR_WAIT_CYC = 82000,
  parameter int          FIFO_DEPTH     = 4
) (
  input  logic       clk,
  input  logic       rst,
  lcd_bus_if.slave   bus,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_on,
  output logic [7:0] lcd_data_out,
  output logic       lcd_data_oe,
  input  logic [7:0] lcd_data_in
);
  localparam int unsigned MAX_A = (INIT_WAIT_CYC > CLEAR_WAIT_CYC) ? INIT_WAIT_CYC : CLEAR_WAIT_CYC;
  localparam int unsigned MAX_B = (CMD_WAIT_CYC > E_PULSE_CYC) ? CMD_WAIT_CYC : E_PULSE_CYC;
  localparam int unsigned MAX_D = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW = $clog2(MAX_D + 1);

  lcd_state_t   r_state, w_state_next;
  logic [CW-1:0] r_cnt, w_cnt_next;
  logic [2:0]   r_idx;
  logic         r_rs;
  logic [7:0]   r_data;
  logic         r_init_done;
  logic         r_overflow;
  logic         r_lcd_on;
  logic [31:0]  r_readdata;

  logic         w_pop, w_init_step, w_init_finish;
  logic [CW-1:0] w_wait_last;
  logic         w_wr_en, w_push;
  logic [8:0]   w_push_data, w_fifo_dout;
  logic         w_fifo_full, w_fifo_empty, w_busy;
  logic [$clog2(FIFO_DEPTH):0] w_fifo_count;
  logic [31:0]  w_status;
  logic         w_unused_bus;

  assign w_wr_en     = bus.write && bus.be[0];
  assign w_push      = w_wr_en && ((bus.address == ADDR_CMD) || (bus.address == ADDR_DATA));
  assign w_push_data = {bus.address == ADDR_DATA, bus.writedata[7:0]};
  assign w_unused_bus = ^{bus.writedata[31:8], bus.be[3:1], w_fifo_count};

  lcd_cmd_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(9)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_din   (w_push_data),
    .i_pop   (w_pop),
    .o_dout  (w_fifo_dout),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  assign w_busy   = (r_state != S_IDLE) || !w_fifo_empty;
  assign w_status = {26'b0, r_overflow, r_init_done, w_busy, w_fifo_empty, w_fifo_full, 1'b0};
  assign w_wait_last = is_slow_cmd(r_rs, r_data) ? CW'(CLEAR_WAIT_CYC - 1) : CW'(CMD_WAIT_CYC - 1);

`ifdef LCD_BUSYFLAG_EN
  logic          r_bf;
  logic [CW-1:0] r_tot;
  logic          w_bf_sample;
  logic          w_poll;
  assign w_poll = (r_state == S_POLL_PULSE) || (r_state == S_POLL_LOW);
`endif

  always_comb begin
    w_state_next  = r_state;
    w_cnt_next    = r_cnt + 1'b1;
    w_pop         = 1'b0;
    w_init_step   = 1'b0;
    w_init_finish = 1'b0;
`ifdef LCD_BUSYFLAG_EN
    w_bf_sample   = 1'b0;
`endif
    case (r_state)
      S_POWERUP: begin
        if (r_cnt == CW'(INIT_WAIT_CYC - 1)) begin
          w_state_next = S_INIT_LOAD;
          w_cnt_next   = '0;
        end
      end
      S_INIT_LOAD: begin
        w_state_next = S_SETUP;
        w_cnt_next   = '0;
      end
      S_IDLE: begin
        w_cnt_next = '0;
        if (!w_fifo_empty) begin
          w_pop        = 1'b1;
          w_state_next = S_SETUP;
        end
      end
      S_SETUP: begin
        w_state_next = S_PULSE;
        w_cnt_next   = '0;
      end
      S_PULSE: begin
        if (r_cnt == CW'(E_PULSE_CYC - 1)) begin
          w_state_next = S_HOLD;
          w_cnt_next   = '0;
        end
      end
      S_HOLD: begin
        w_cnt_next   = '0;
`ifdef LCD_BUSYFLAG_EN
        w_state_next = r_init_done ? S_POLL_PULSE : S_WAIT;
`else
        w_state_next = S_WAIT;
`endif
      end
      S_WAIT: begin
        if (r_cnt == w_wait_last) begin
          w_cnt_next = '0;
          if (r_init_done) begin
            w_state_next = S_IDLE;
          end else if (r_idx == 3'(INIT_LEN - 1)) begin
            w_init_finish = 1'b1;
            w_state_next  = S_IDLE;
          end else begin
            w_init_step  = 1'b1;
            w_state_next = S_INIT_LOAD;
          end
        end
      end
`ifdef LCD_BUSYFLAG_EN
      // BF is sampled on the last high cycle of each read strobe.
      S_POLL_PULSE: begin
        if (r_cnt == CW'(E_PULSE_CYC - 1)) begin
          w_bf_sample  = 1'b1;
          w_state_next = S_POLL_LOW;
          w_cnt_next   = '0;
        end
      end
      S_POLL_LOW: begin
        w_cnt_next   = '0;
        w_state_next = (r_bf && (r_tot < CW'(CLEAR_WAIT_CYC))) ? S_POLL_PULSE : S_IDLE;
      end
`endif
      default: begin
        w_state_next = S_POWERUP;
        w_cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_POWERUP;
      r_cnt       <= '0;
      r_idx       <= '0;
      r_rs        <= 1'b0;
      r_data      <= 8'h00;
      r_init_done <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (r_state == S_INIT_LOAD) begin
        r_rs   <= 1'b0;
        r_data <= init_rom(r_idx);
      end else if (w_pop) begin
        r_rs   <= w_fifo_dout[8];
        r_data <= w_fifo_dout[7:0];
      end
      if (w_init_step)   r_idx       <= r_idx + 1'b1;
      if (w_init_finish) r_init_done <= 1'b1;
    end
  end

`ifdef LCD_BUSYFLAG_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bf  <= 1'b0;
      r_tot <= '0;
    end else begin
      if (w_bf_sample) r_bf <= lcd_data_in[7];
      r_tot <= w_poll ? r_tot + 1'b1 : '0;
    end
  end
`endif

  // A new overflow wins over the clear-on-read of STATUS in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow <= 1'b0;
      r_lcd_on   <= 1'b1;
      r_readdata <= '0;
    end else begin
      if (w_push && w_fifo_full) begin
        r_overflow <= 1'b1;
      end else if (bus.read && (bus.address == ADDR_STATUS)) begin
        r_overflow <= 1'b0;
      end
      if (w_wr_en && (bus.address == ADDR_CTRL)) begin
        r_lcd_on <= bus.writedata[0];
      end
      if (bus.read) begin
        case (bus.address)
          ADDR_STATUS: r_readdata <= w_status;
          ADDR_CTRL:   r_readdata <= {31'b0, r_lcd_on};
          default:     r_readdata <= '0;
        endcase
      end
    end
  end

  assign bus.readdata = r_readdata;
  assign lcd_on       = r_lcd_on;
  assign lcd_data_out = r_data;

`ifdef LCD_BUSYFLAG_EN
  assign lcd_e       = (r_state == S_PULSE) || (r_state == S_POLL_PULSE);
  assign lcd_rw      = w_poll;
  assign lcd_data_oe = !w_poll;
  assign lcd_rs      = w_poll ? 1'b0 : r_rs;
`else
  logic w_unused_din;
  assign w_unused_din = ^lcd_data_in;
  assign lcd_e        = (r_state == S_PULSE);
  assign lcd_rw       = 1'b0;
  assign lcd_data_oe  = 1'b1;
  assign lcd_rs       = r_rs;
`endif
endmodule

// File: tb/tb_lcd_sequencer.sv
// Self-checking bench for lcd_sequencer with small delays; a pin monitor records every
// write strobe and compares it against a transfer-level model of the expected traffic.
module tb_lcd_sequencer;
  localparam int P_INIT = 10, P_E = 2, P_CMD = 5, P_CLEAR = 9, P_DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lcd_bus_if bif ();
  logic       lcd_e, lcd_rs, lcd_rw, lcd_on, lcd_data_oe;
  logic [7:0] lcd_data_out, lcd_data_in;

  int errors = 0;
  int checks = 0;
  int poll_cnt = 0;
  int bf_limit = 0;

  assign lcd_data_in = {(poll_cnt < bf_limit), 7'b0};

  lcd_sequencer #(
    .INIT_WAIT_CYC(P_INIT), .E_PULSE_CYC(P_E), .CMD_WAIT_CYC(P_CMD),
    .CLEAR_WAIT_CYC(P_CLEAR), .FIFO_DEPTH(P_DEPTH)
  ) dut (
    .clk(clk), .rst(rst), .bus(bif),
    .lcd_e(lcd_e), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_on(lcd_on),
    .lcd_data_out(lcd_data_out), .lcd_data_oe(lcd_data_oe), .lcd_data_in(lcd_data_in)
  );

  typedef struct {
    bit         rs;
    bit         rw;
    bit         oe;
    logic [7:0] data;
    int         width;
    int         gap;
  } xfer_t;

  xfer_t obs_q[$];
  xfer_t cur;
  logic [7:0] init_seq [8] = '{8'h38, 8'h38, 8'h38, 8'h38, 8'h08, 8'h01, 8'h06, 8'h0C};

  // Settle time the LCD needs after a write of this kind.
  function automatic int settle_of(input bit rs, input logic [7:0] d);
    return (!rs && d >= 8'h01 && d <= 8'h03) ? P_CLEAR : P_CMD;
  endfunction

  // Pin monitor: gap = low cycles since previous strobe, width = high cycles.
  initial begin
    int low_cnt, hi_cnt;
    bit in_pulse;
    low_cnt = 0; hi_cnt = 0; in_pulse = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        in_pulse = 0;
        low_cnt  = 0;
      end else if (lcd_e) begin
        if (!in_pulse) begin
          in_pulse = 1;
          cur.rs = lcd_rs; cur.rw = lcd_rw; cur.oe = lcd_data_oe;
          cur.data = lcd_data_out; cur.gap = low_cnt;
          hi_cnt = 0;
        end
        hi_cnt++;
      end else begin
        if (in_pulse) begin
          in_pulse = 0;
          cur.width = hi_cnt;
          low_cnt = 0;
          if (cur.rw && !cur.oe) poll_cnt++;
          else obs_q.push_back(cur);
        end
        low_cnt++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d, input logic [3:0] b);
    @(posedge clk); #1;
    bif.write = 1'b1; bif.address = a; bif.writedata = d; bif.be = b;
    @(posedge clk); #1;
    bif.write = 1'b0; bif.be = 4'h0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] v);
    @(posedge clk); #1;
    bif.read = 1'b1; bif.address = a;
    @(posedge clk); #1;
    bif.read = 1'b0;
    v = bif.readdata;
  endtask

  task automatic check_status(input string name, input logic [31:0] exp);
    logic [31:0] v;
    bus_read(2'd2, v);
    checks++;
    if (v !== exp) begin
      errors++;
      $display("FAIL %s: STATUS got %08h, required %08h", name, v, exp);
    end else $display("read STATUS %s = %08h", name, v);
  endtask

  task automatic wait_xfers(input string name, input int n, input int budget);
    int t;
    t = 0;
    while (obs_q.size() < n && t < budget) begin
      @(posedge clk); t++;
    end
    checks++;
    if (obs_q.size() < n) begin
      errors++;
      $display("FAIL %s timeout: got %0d transfers, required %0d", name, obs_q.size(), n);
    end
  endtask

  // Compares observed strobes against expected {rs,data} list; optional exact gaps.
  task automatic check_xfers(input string name, input bit exp_rs[$], input logic [7:0] exp_d[$],
                             input int gap_from, input int gap_to);
    xfer_t x;
    for (int i = 0; i < exp_d.size(); i++) begin
      x = (i < obs_q.size()) ? obs_q[i] : '{0, 0, 0, 8'hxx, 0, 0};
      $display("xfer %s[%0d] rs=%0d rw=%0d data=%02h width=%0d gap=%0d",
               name, i, x.rs, x.rw, x.data, x.width, x.gap);
      checks++;
      if ({x.rs, x.rw, x.oe, x.data} !== {exp_rs[i], 1'b0, 1'b1, exp_d[i]}) begin
        errors++;
        $display("FAIL %s[%0d] rs/rw/oe/data: got %0d/%0d/%0d/%02h, required %0d/0/1/%02h",
                 name, i, x.rs, x.rw, x.oe, x.data, exp_rs[i], exp_d[i]);
      end
      checks++;
      if (x.width != P_E) begin
        errors++;
        $display("FAIL %s[%0d] e width: got %0d, required %0d", name, i, x.width, P_E);
      end
      if (i >= gap_from && i <= gap_to && i > 0) begin
        checks++;
        if (x.gap != settle_of(exp_rs[i-1], exp_d[i-1]) + 3) begin
          errors++;
          $display("FAIL %s[%0d] gap: got %0d, required %0d", name, i, x.gap,
                   settle_of(exp_rs[i-1], exp_d[i-1]) + 3);
        end
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    obs_q.delete();
  endtask

  task automatic test_reset();
    logic [31:0] v;
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({lcd_e, lcd_rs, lcd_rw, lcd_on, lcd_data_out, lcd_data_oe} !== {4'b0001, 8'h00, 1'b1}) begin
      errors++;
      $display("FAIL reset pins: got e=%0b rs=%0b rw=%0b on=%0b d=%02h oe=%0b, required 0 0 0 1 00 1",
               lcd_e, lcd_rs, lcd_rw, lcd_on, lcd_data_out, lcd_data_oe);
    end
    checks++;
    if (bif.readdata !== 32'h0) begin
      errors++;
      $display("FAIL reset readdata: got %08h, required 00000000", bif.readdata);
    end
    rst = 1'b0;
    obs_q.delete();
    check_status("reset", 32'h0000_000C);
  endtask

  task automatic test_init();
    bit rs_q[$];
    logic [7:0] d_q[$];
    for (int i = 0; i < 8; i++) begin rs_q.push_back(1'b0); d_q.push_back(init_seq[i]); end
    wait_xfers("init", 8, 2000);
    check_xfers("init", rs_q, d_q, 1, 7);
    obs_q.delete();
    repeat (20) @(posedge clk);
    check_status("init_done", 32'h0000_0014);
  endtask

  task automatic test_data();
    bit rs_q[$];
    logic [7:0] d_q[$];
    for (int k = 0; k < 5; k++) begin
      bit rs;
      logic [7:0] d;
      rs = (k == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      d  = (k == 0) ? 8'h41 : 8'($urandom_range(0, 255));
      rs_q.delete(); d_q.delete();
      rs_q.push_back(rs); d_q.push_back(d);
      obs_q.delete();
      bus_write(rs ? 2'd1 : 2'd0, {24'hABCDEF, d}, 4'hF);
      wait_xfers("data", 1, 200);
      check_xfers("data", rs_q, d_q, 1, 0);
      repeat (settle_of(rs, d) + 8) @(posedge clk);
    end
    obs_q.delete();
    check_status("data_idle", 32'h0000_0014);
  endtask

  task automatic test_overflow();
    bit rs_q[$];
    logic [7:0] d_q[$];
    do_reset();
    for (int i = 0; i < 8; i++) begin rs_q.push_back(1'b0); d_q.push_back(init_seq[i]); end
    for (int k = 0; k < 5; k++) begin
      bit rs;
      logic [7:0] d;
      rs = (k == 1) ? 1'b0 : 1'($urandom_range(0, 1));
      d  = (k == 1) ? 8'h02 : 8'($urandom_range(0, 255));
      if (k < P_DEPTH) begin rs_q.push_back(rs); d_q.push_back(d); end
      bus_write(rs ? 2'd1 : 2'd0, {24'h0, d}, 4'h1);
    end
    check_status("overflow", 32'h0000_002A);
    check_status("overflow_cleared", 32'h0000_000A);
    wait_xfers("ovf", 12, 3000);
`ifdef LCD_BUSYFLAG_EN
    check_xfers("ovf", rs_q, d_q, 1, 8);
`else
    check_xfers("ovf", rs_q, d_q, 1, 11);
`endif
    repeat (30) @(posedge clk);
    checks++;
    if (obs_q.size() != 12) begin
      errors++;
      $display("FAIL ovf count: got %0d transfers, required 12", obs_q.size());
    end
    obs_q.delete();
    check_status("ovf_idle", 32'h0000_0014);
  endtask

  task automatic test_be_ctrl();
    logic [31:0] v;
    bus_write(2'd1, 32'h0000_0055, 4'b1110);
    repeat (30) @(posedge clk);
    checks++;
    if (obs_q.size() != 0) begin
      errors++;
      $display("FAIL be_ignore: got %0d transfers, required 0", obs_q.size());
    end
    check_status("be_ignore", 32'h0000_0014);
    bus_write(2'd3, 32'h0000_0000, 4'b0001);
    checks++;
    if (lcd_on !== 1'b0) begin errors++; $display("FAIL ctrl_off: lcd_on got %0b, required 0", lcd_on); end
    bus_read(2'd3, v);
    checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL ctrl_read0: got %08h, required 00000000", v); end
    bus_write(2'd3, 32'h0000_0001, 4'b1110);
    checks++;
    if (lcd_on !== 1'b0) begin errors++; $display("FAIL ctrl_be: lcd_on got %0b, required 0", lcd_on); end
    bus_write(2'd3, 32'hFFFF_FFFF, 4'b1111);
    bus_read(2'd3, v);
    checks++;
    if (v !== 32'h1 || lcd_on !== 1'b1) begin
      errors++;
      $display("FAIL ctrl_on: got read %08h lcd_on %0b, required 00000001 1", v, lcd_on);
    end
    bus_read(2'd1, v);
    checks++;
    if (v !== 32'h0) begin errors++; $display("FAIL data_read: got %08h, required 00000000", v); end
    $display("ctrl and byte-enable transactions done");
  endtask

  task automatic test_reset_mid();
    int t;
    bit rs_q[$];
    logic [7:0] d_q[$];
    bus_write(2'd1, 32'h0000_0061, 4'h1);
    bus_write(2'd1, 32'h0000_0062, 4'h1);
    t = 0;
    while (lcd_e !== 1'b1 && t < 50) begin @(posedge clk); #1; t++; end
    checks++;
    if (lcd_e !== 1'b1) begin errors++; $display("FAIL reset_mid: no strobe within 50 cycles"); end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (lcd_e !== 1'b0) begin errors++; $display("FAIL reset_mid e: got %0b, required 0", lcd_e); end
    rst = 1'b0;
    obs_q.delete();
    check_status("reset_mid", 32'h0000_000C);
    for (int i = 0; i < 8; i++) begin rs_q.push_back(1'b0); d_q.push_back(init_seq[i]); end
    wait_xfers("restart", 8, 2000);
    check_xfers("restart", rs_q, d_q, 1, 7);
    repeat (40) @(posedge clk);
    checks++;
    if (obs_q.size() != 8) begin
      errors++;
      $display("FAIL reset_mid flush: got %0d transfers, required 8", obs_q.size());
    end
    obs_q.delete();
  endtask

`ifdef LCD_BUSYFLAG_EN
  task automatic test_busyflag();
    int base, t;
    base = poll_cnt;
    bf_limit = base + 3;
    bus_write(2'd1, 32'h0000_0077, 4'h1);
    t = 0;
    while (poll_cnt < base + 4 && t < 300) begin @(posedge clk); t++; end
    repeat (10) @(posedge clk);
    checks++;
    if (poll_cnt - base != 4) begin
      errors++;
      $display("FAIL busyflag polls: got %0d, required 4", poll_cnt - base);
    end
    $display("busyflag polls=%0d", poll_cnt - base);
    bf_limit = 0;
    obs_q.delete();
    check_status("busyflag_idle", 32'h0000_0014);
  endtask
`endif

  initial begin
    bif.read = 1'b0; bif.write = 1'b0; bif.address = 2'd0;
    bif.writedata = 32'h0; bif.be = 4'h0;
    test_reset();
    test_init();
    test_data();
    test_overflow();
    test_be_ctrl();
    test_reset_mid();
`ifdef LCD_BUSYFLAG_EN
    test_busyflag();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
